// File: rtl/cb_prog_if.sv
// cb_prog_if -- configuration-loader handshake bundle for cb_prog.
//
// Handshake: a configuration word moves from master to slave on every rising
// clock edge where cfg_valid and cfg_ready are both high. The master keeps
// cfg_data stable while cfg_valid is high and cfg_ready is low. cfg_ready does
// not depend on cfg_valid.
//
// Signals (direction seen from the slave, i.e. cb_prog):
//   cfg_start     in   begin a new load
//   cfg_valid     in   cfg_data valid
//   cfg_ready     out  loader accepts a word
//   cfg_data      in   configuration word, CFG_WORD bits
//   cfg_commit    in   copy shadow to active config
//   cfg_abort     in   abandon the load in progress
//   cfg_busy      out  loader not idle
//   cfg_done      out  one-cycle pulse after a completed commit
//   cfg_conflict  out  active config has two or more pins driving one track
//   cfg_state     out  loader FSM state (debug)
//   cfg_dout      out  word shifted out of the shadow   (CB_CFG_READBACK_EN only)
//   cfg_dout_valid out one-cycle pulse per shifted word (CB_CFG_READBACK_EN only)
interface cb_cfg_if #(
    parameter int CFG_WORD = 8
);
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_WORD-1:0] cfg_data;
    logic                cfg_commit;
    logic                cfg_abort;
    logic                cfg_busy;
    logic                cfg_done;
    logic                cfg_conflict;
    logic [1:0]          cfg_state;
`ifdef CB_CFG_READBACK_EN
    logic [CFG_WORD-1:0] cfg_dout;
    logic                cfg_dout_valid;
`endif

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_commit, cfg_abort,
        input  cfg_ready, cfg_busy, cfg_done, cfg_conflict, cfg_state
`ifdef CB_CFG_READBACK_EN
        , input cfg_dout, cfg_dout_valid
`endif
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_commit, cfg_abort,
        output cfg_ready, cfg_busy, cfg_done, cfg_conflict, cfg_state
`ifdef CB_CFG_READBACK_EN
        , output cfg_dout, cfg_dout_valid
`endif
    );
endinterface

// File: rtl/cb_prog.sv
// cb_prog -- programmable connection box between logic-block pins and routing
// tracks, with a shift-in shadow configuration and an atomic commit.
//
// Each pin owns an FW-bit field: bit 0 = dir (0 track->pin, 1 pin->track),
// bits [FW-1:1] = sel (0 or > NUM_TRACKS = unconnected, k = track k-1).
// Words shift in at the MSB end of the shadow, so the first word sent lands
// at the LSBs. Routing is driven only by the active copy.
//
// Optional feature macro: CB_CFG_READBACK_EN adds cfg_dout/cfg_dout_valid,
// which present the shadow word displaced by each accepted word.
//
// Ports:
//   clk      clock, all state on its rising edge
//   rst      synchronous active-high reset
//   cfg      cb_cfg_if.slave loader handshake bundle
//   pin_in   logic-block outputs            (NUM_PINS)
//   pin_out  logic-block inputs             (NUM_PINS)
//   trk_in   track values                   (NUM_TRACKS)
//   trk_out  track drive value              (NUM_TRACKS)
//   trk_oe   track drive enable             (NUM_TRACKS)
module cb_prog #(
    parameter int NUM_PINS   = 7,
    parameter int NUM_TRACKS = 8,
    parameter int CFG_WORD   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cb_cfg_if.slave               cfg,
    input  logic [NUM_PINS-1:0]   pin_in,
    output logic [NUM_PINS-1:0]   pin_out,
    input  logic [NUM_TRACKS-1:0] trk_in,
    output logic [NUM_TRACKS-1:0] trk_out,
    output logic [NUM_TRACKS-1:0] trk_oe
);
    localparam int SELW     = $clog2(NUM_TRACKS + 1);
    localparam int FW       = SELW + 1;
    localparam int CFG_BITS = NUM_PINS * FW;
    localparam int NWORDS   = (CFG_BITS + CFG_WORD - 1) / CFG_WORD;
    localparam int SHW      = NWORDS * CFG_WORD;
    localparam int CNTW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNTW-1:0]     cnt, cnt_n;
    logic [SHW-1:0]      shadow;
    logic [CFG_BITS-1:0] active;
    logic                accept;
    logic                do_commit;
    logic                shadow_conflict;
    logic                done_q;
    logic                conflict_q;

    assign cfg.cfg_ready    = (state == ST_LOAD);
    assign cfg.cfg_busy     = (state != ST_IDLE);
    assign cfg.cfg_done     = done_q;
    assign cfg.cfg_conflict = conflict_q;
    assign cfg.cfg_state    = state;

    // A handshake always shifts the word in; abort/start only steer the
    // state and count, so the shadow is never cleared by them.
    assign accept = cfg.cfg_valid && (state == ST_LOAD);

    // Control priority while busy: abort > commit > start > word count.
    // Commit is meaningless in LOAD, so there start is the next contender.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        do_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg.cfg_start) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg.cfg_abort) begin
                    state_n = ST_IDLE;
                end else if (cfg.cfg_start) begin
                    cnt_n = '0;
                end else if (accept) begin
                    if (cnt == CNTW'(NWORDS - 1)) begin
                        state_n = ST_WAIT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cfg.cfg_abort) begin
                    state_n = ST_IDLE;
                end else if (cfg.cfg_commit) begin
                    state_n   = ST_IDLE;
                    do_commit = 1'b1;
                end else if (cfg.cfg_start) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Conflict of the pending shadow, latched at commit so cfg_conflict
    // always describes the active configuration.
    always_comb begin
        logic [NUM_TRACKS-1:0] seen;
        logic [SELW-1:0]       sel;
        seen            = '0;
        sel             = '0;
        shadow_conflict = 1'b0;
        for (int p = 0; p < NUM_PINS; p++) begin
            sel = shadow[p*FW+1 +: SELW];
            if (shadow[p*FW]) begin
                for (int t = 0; t < NUM_TRACKS; t++) begin
                    if (sel == SELW'(t + 1)) begin
                        if (seen[t]) shadow_conflict = 1'b1;
                        seen[t] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_q <= do_commit;
            if (accept) shadow <= {cfg.cfg_data, shadow[SHW-1:CFG_WORD]};
            if (do_commit) begin
                active     <= shadow[CFG_BITS-1:0];
                conflict_q <= shadow_conflict;
            end
        end
    end

`ifdef CB_CFG_READBACK_EN
    logic [CFG_WORD-1:0] dout_q;
    logic                dout_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= accept;
            if (accept) dout_q <= shadow[CFG_WORD-1:0];
        end
    end

    assign cfg.cfg_dout       = dout_q;
    assign cfg.cfg_dout_valid = dout_valid_q;
`endif

    // Routing from the active copy only. Tracks are claimed in ascending pin
    // order, so the lowest-index driving pin wins a contended track.
    always_comb begin
        logic [SELW-1:0] sel;
        sel     = '0;
        pin_out = '0;
        trk_out = '0;
        trk_oe  = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            sel = active[p*FW+1 +: SELW];
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (sel == SELW'(t + 1)) begin
                    if (!active[p*FW]) begin
                        pin_out[p] = trk_in[t];
                    end else if (!trk_oe[t]) begin
                        trk_oe[t]  = 1'b1;
                        trk_out[t] = pin_in[p];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cb_prog.sv
// tb_cb_prog -- directed self-checking bench for cb_prog (default parameters:
// 7 pins, 8 tracks, 8-bit words, 5 words per load, 5-bit pin fields).
module tb_cb_prog;
    logic       clk;
    logic       rst;
    logic [6:0] pin_in;
    logic [6:0] pin_out;
    logic [7:0] trk_in;
    logic [7:0] trk_out;
    logic [7:0] trk_oe;

    int n_vec;
    int n_err;

    cb_cfg_if #(.CFG_WORD(8)) cif ();

    cb_prog #(
        .NUM_PINS  (7),
        .NUM_TRACKS(8),
        .CFG_WORD  (8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .cfg    (cif.slave),
        .pin_in (pin_in),
        .pin_out(pin_out),
        .trk_in (trk_in),
        .trk_out(trk_out),
        .trk_oe (trk_oe)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        cif.cfg_start = 1'b1;
        tick();
        cif.cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = w;
        tick();
        cif.cfg_valid = 1'b0;
        cif.cfg_data  = '0;
    endtask

    task automatic load_words(input logic [39:0] c);
        do_start();
        for (int i = 0; i < 5; i++) send_word(c[i*8 +: 8]);
    endtask

    task automatic do_commit(input string tag);
        cif.cfg_commit = 1'b1;
        tick();
        cif.cfg_commit = 1'b0;
        check({tag, "_done_hi"}, cif.cfg_done, 1'b1);
        tick();
        check({tag, "_done_lo"}, cif.cfg_done, 1'b0);
    endtask

    // Scoreboard for readback words
    logic [7:0] exp_q[$];
    logic       rb_on;
    logic [7:0] rb_exp;

`ifdef CB_CFG_READBACK_EN
    always @(negedge clk) begin
        if (rb_on && cif.cfg_dout_valid) begin
            if (exp_q.size() == 0) begin
                check("rb_unexpected", cif.cfg_dout, 8'hxx);
            end else begin
                rb_exp = exp_q.pop_front();
                check("rb_dout", cif.cfg_dout, rb_exp);
            end
        end
    end
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rb_on = 1'b0;
        rst = 1'b1;
        pin_in = '0;
        trk_in = '0;
        cif.cfg_start = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_data = '0;
        cif.cfg_commit = 1'b0;
        cif.cfg_abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state after 10 idle cycles
        for (int i = 0; i < 10; i++) tick();
        trk_in = 8'hFF;
        pin_in = 7'h7F;
        #1;
        check("rst_pin_out",  pin_out, 7'h00);
        check("rst_trk_oe",   trk_oe, 8'h00);
        check("rst_trk_out",  trk_out, 8'h00);
        check("rst_busy",     cif.cfg_busy, 1'b0);
        check("rst_conflict", cif.cfg_conflict, 1'b0);
        check("rst_ready",    cif.cfg_ready, 1'b0);
        check("rst_done",     cif.cfg_done, 1'b0);
        check("rst_state",    cif.cfg_state, 2'd0);

        // pin0 dir=1 sel=1 (track 0); 0x83 bit 7 gives pin1 dir=0 sel=2
        do_start();
        check("ld_ready", cif.cfg_ready, 1'b1);
        check("ld_busy",  cif.cfg_busy, 1'b1);
        send_word(8'h83);
        for (int i = 0; i < 4; i++) send_word(8'h00);
        check("wait_ready", cif.cfg_ready, 1'b0);
        check("wait_busy",  cif.cfg_busy, 1'b1);
        check("wait_state", cif.cfg_state, 2'd2);
        check("wait_trk_oe_old", trk_oe, 8'h00);
        do_commit("c1");
        check("c1_busy", cif.cfg_busy, 1'b0);
        check("c1_trk_oe", trk_oe, 8'h01);
        pin_in = 7'h01; #1;
        check("c1_trk_out_1", trk_out, 8'h01);
        pin_in = 7'h7E; #1;
        check("c1_trk_out_0", trk_out, 8'h00);
        trk_in = 8'h02; #1;
        check("c1_pin_out_1", pin_out, 7'h02);
        trk_in = 8'hFD; #1;
        check("c1_pin_out_0", pin_out, 7'h00);
        check("c1_conflict", cif.cfg_conflict, 1'b0);

        // pin0 dir=0 sel=3, pin1 dir=1 sel=3 -> 0xE6
        load_words(40'h00_0000_00E6);
        check("c2_live_oe_before_commit", trk_oe, 8'h01);
        do_commit("c2");
        trk_in = 8'h04; #1;
        check("c2_pin_out_1", pin_out, 7'h01);
        trk_in = 8'hFB; #1;
        check("c2_pin_out_0", pin_out, 7'h00);
        pin_in = 7'h02; #1;
        check("c2_trk_oe", trk_oe, 8'h04);
        check("c2_trk_out_1", trk_out, 8'h04);
        pin_in = 7'h7D; #1;
        check("c2_trk_out_0", trk_out, 8'h00);
        check("c2_conflict", cif.cfg_conflict, 1'b0);

        // add pin2 dir=1 sel=3 -> 0x1CE6, pin1 keeps track 2
        load_words(40'h00_0000_1CE6);
        do_commit("c3");
        check("c3_conflict", cif.cfg_conflict, 1'b1);
        pin_in = 7'h04; #1;
        check("c3_trk_oe", trk_oe, 8'h04);
        check("c3_pin2_loses", trk_out, 8'h00);
        pin_in = 7'h02; #1;
        check("c3_pin1_wins", trk_out, 8'h04);

        // Abort after 3 of 5 words, then commit is ignored
        do_start();
        for (int i = 0; i < 3; i++) send_word(8'hFF);
        cif.cfg_abort = 1'b1;
        tick();
        cif.cfg_abort = 1'b0;
        check("ab_busy", cif.cfg_busy, 1'b0);
        cif.cfg_commit = 1'b1;
        tick();
        cif.cfg_commit = 1'b0;
        check("ab_done_0", cif.cfg_done, 1'b0);
        tick();
        check("ab_done_1", cif.cfg_done, 1'b0);
        check("ab_conflict", cif.cfg_conflict, 1'b1);
        check("ab_trk_oe", trk_oe, 8'h04);
        check("ab_trk_out", trk_out, 8'h04);

        // Restart mid-load: 5 fresh words needed, they fully define shadow
        do_start();
        for (int i = 0; i < 3; i++) send_word(8'hFF);
        do_start();
        check("rs_ready", cif.cfg_ready, 1'b1);
        send_word(8'h03);
        for (int i = 0; i < 3; i++) send_word(8'h00);
        check("rs_ready_after4", cif.cfg_ready, 1'b1);
        send_word(8'h00);
        check("rs_ready_after5", cif.cfg_ready, 1'b0);
        check("rs_busy_after5", cif.cfg_busy, 1'b1);
        do_commit("rs");
        check("rs_trk_oe", trk_oe, 8'h01);
        check("rs_conflict", cif.cfg_conflict, 1'b0);

        // cfg_valid held high through WAIT; pin3 dir=1 sel=8 -> 0x88000
        do_start();
        cif.cfg_valid = 1'b1;
        cif.cfg_data = 8'h00; tick();
        cif.cfg_data = 8'h80; tick();
        cif.cfg_valid = 1'b0;
        cif.cfg_data = 8'hEE; tick();
        cif.cfg_valid = 1'b1;
        cif.cfg_data = 8'h08; tick();
        cif.cfg_data = 8'h00; tick();
        cif.cfg_data = 8'h00; tick();
        cif.cfg_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check("hv_ready_wait", cif.cfg_ready, 1'b0);
            tick();
        end
        cif.cfg_valid = 1'b0;
        do_commit("hv");
        pin_in = 7'h08; #1;
        check("hv_trk_oe", trk_oe, 8'h80);
        check("hv_trk_out", trk_out, 8'h80);

        // Reset mid-load
        trk_in = 8'hFF;
        pin_in = 7'h7F;
        do_start();
        send_word(8'h03);
        send_word(8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", cif.cfg_busy, 1'b0);
        check("mr_ready", cif.cfg_ready, 1'b0);
        check("mr_pin_out", pin_out, 7'h00);
        check("mr_trk_oe", trk_oe, 8'h00);
        check("mr_trk_out", trk_out, 8'h00);
        check("mr_conflict", cif.cfg_conflict, 1'b0);
        check("mr_done", cif.cfg_done, 1'b0);
        cif.cfg_commit = 1'b1;
        tick();
        cif.cfg_commit = 1'b0;
        check("mr_commit_ignored", cif.cfg_done, 1'b0);

`ifdef CB_CFG_READBACK_EN
        // Two loads after reset: first displaces zeros, second the first's words
        rb_on = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
        load_words(40'h55_4433_2211);
        do_commit("rb1");
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        load_words(40'hAA_BBCC_DDEE);
        do_commit("rb2");
        tick();
        check("rb_queue_empty", exp_q.size(), 0);
        rb_on = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
